// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: default sizes and helper functions.
package bp_pkg;

  localparam int unsigned BP_IDX_W = 4;
  localparam int unsigned BP_CNT_W = 2;
  localparam int unsigned BP_GHR_W = 4;

  // Widest supported counter and index; helpers work at these widths and callers cast down.
  localparam int unsigned BP_CNT_MAX_W = 4;
  localparam int unsigned BP_IDX_MAX_W = 10;

  // Reset value of every counter: weakly not-taken, 2^(cnt_w-1) - 1.
  function automatic logic [BP_CNT_MAX_W-1:0] cnt_init(input int unsigned cnt_w);
    return 4'((5'd1 << (cnt_w - 1)) - 5'd1);
  endfunction

  // Saturating step towards taken (up) or not-taken, clamped to [0, 2^cnt_w - 1].
  function automatic logic [BP_CNT_MAX_W-1:0] sat_update(input logic [BP_CNT_MAX_W-1:0] c,
                                                          input logic up,
                                                          input int unsigned cnt_w);
    logic [BP_CNT_MAX_W-1:0] cmax;
    cmax = 4'((5'd1 << cnt_w) - 5'd1);
    if (up) return (c == cmax) ? c : c + 4'd1;
    return (c == 4'd0) ? c : c - 4'd1;
  endfunction

  // gshare index: word-address bits of the PC XOR the low ghr_w history bits.
  function automatic logic [BP_IDX_MAX_W-1:0] idx_hash(input logic [31:0] pc,
                                                        input logic [BP_IDX_MAX_W-1:0] h,
                                                        input int unsigned idx_w,
                                                        input int unsigned ghr_w);
    logic [BP_IDX_MAX_W-1:0] imask;
    logic [BP_IDX_MAX_W-1:0] hmask;
    imask = 10'((11'd1 << idx_w) - 11'd1);
    hmask = 10'((11'd1 << ghr_w) - 11'd1);
    return (pc[11:2] & imask) ^ (h & hmask);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating direction counters: one async read port, one sync update port.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned CNT_W = BP_CNT_W,
  parameter logic [CNT_W-1:0] INIT = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_up
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [CNT_W-1:0] cnt [DEPTH];

  // Lookup reads the current (pre-update) value.
  assign rd_cnt = cnt[rd_idx];

  // Reset to the init value; otherwise step the addressed counter with saturation.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) cnt[i] <= INIT;
    end else if (wr_en) begin
      cnt[wr_idx] <= CNT_W'(sat_update(4'(cnt[wr_idx]), wr_up, CNT_W));
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare branch predictor: combinational lookup, speculative history, mispredict recovery and stats.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W  = BP_IDX_W,
  parameter int unsigned CNT_W  = BP_CNT_W,
  parameter int unsigned GHR_W  = BP_GHR_W,
  parameter int unsigned STAT_W = 32,
  localparam int unsigned HW    = (GHR_W == 0) ? 1 : GHR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              pred_valid,
  input  logic              pred_branch,
  input  logic              pred_jump,
  input  logic [31:0]       pred_pc,
  input  logic [31:0]       pred_imm,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [HW-1:0]     pred_ghr,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [HW-1:0]     res_ghr,
  input  logic              res_pred_taken,
  input  logic              res_taken,
  input  logic [31:0]       res_target,
  output logic              predict_fail,
  output logic [31:0]       fail_addr,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_misses
);

  logic [HW-1:0]    ghr;
  logic [HW-1:0]    ghr_shift;
  logic [HW-1:0]    ghr_restore;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic             res_fire;
  logic             mispredict;

  bp_counter_table #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W),
    .INIT  (CNT_W'(cnt_init(CNT_W)))
  ) u_table (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rd_idx (rd_idx),
    .rd_cnt (rd_cnt),
    .wr_en  (res_fire),
    .wr_idx (wr_idx),
    .wr_up  (res_taken)
  );

  // Lookup path, resolve qualification and next-history candidates.
  always_comb begin
    rd_idx      = IDX_W'(idx_hash(pred_pc, 10'(ghr), IDX_W, GHR_W));
    wr_idx      = IDX_W'(idx_hash(res_pc, 10'(res_ghr), IDX_W, GHR_W));
    pred_taken  = pred_valid & (pred_jump | (pred_branch & rd_cnt[CNT_W-1]));
    pred_target = pred_pc + pred_imm;
    pred_ghr    = ghr;
    res_fire    = rdy_in & res_valid;
    mispredict  = res_fire & (res_taken != res_pred_taken);
    // Truncating {h, bit} to HW keeps the youngest HW-1 bits of h plus the new bit.
    ghr_shift   = (GHR_W == 0) ? '0 : HW'({ghr, pred_taken});
    ghr_restore = (GHR_W == 0) ? '0 : HW'({res_ghr, res_taken});
  end

  // History, fail pulse and statistics; a mispredict restore overrides the lookup shift.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ghr           <= '0;
      predict_fail  <= 1'b0;
      fail_addr     <= '0;
      stat_branches <= '0;
      stat_misses   <= '0;
    end else if (rdy_in) begin
      predict_fail <= mispredict;
      if (mispredict) begin
        fail_addr <= res_taken ? res_target : res_pc + 32'd4;
        ghr       <= ghr_restore;
      end else if (pred_valid && pred_branch) begin
        ghr <= ghr_shift;
      end
      if (res_valid)  stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict) stat_misses   <= stat_misses + STAT_W'(1);
    end
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the single-cycle branch predictor in instFetch.
- Keeps a table of 2^IDX_W saturating counters, indexed by gshare (PC XOR global history), with speculative global-history update and recovery on mispredict.
- Sits beside the fetch unit. Fetch queries it combinationally and gets a direction plus a target. The execute/ROB side sends resolved branches back, and the block raises predict_fail with a redirect address.

Parameters:
- IDX_W, 4, log2 of counter-table entries (1..10)
- CNT_W, 2, counter width in bits (1..4)
- GHR_W, 4, global-history length in bits; 0 means pure bimodal (PC-indexed). Must be <= IDX_W.
- STAT_W, 32, width of the statistics counters

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global ready; when 0, all state holds
- pred_valid  in  1  fetch lookup request this cycle
- pred_branch  in  1  instruction is a conditional branch
- pred_jump  in  1  instruction is JAL (always taken)
- pred_pc  in  32  PC of the instruction
- pred_imm  in  32  sign-extended immediate
- pred_taken  out  1  predicted direction (combinational)
- pred_target  out  32  pred_pc + pred_imm (combinational)
- pred_ghr  out  max(GHR_W,1)  history snapshot used for this lookup; travels with the instruction
- res_valid  in  1  resolved conditional branch
- res_pc  in  32  PC of the resolved branch
- res_ghr  in  max(GHR_W,1)  snapshot returned from pred_ghr
- res_pred_taken  in  1  direction originally predicted
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- predict_fail  out  1  one-cycle pulse: a prior prediction was wrong
- fail_addr  out  32  correct next PC, valid while predict_fail = 1
- stat_branches  out  STAT_W  count of resolved branches
- stat_misses  out  STAT_W  count of mispredicts

Behaviour:
- Index arithmetic:
  - idx(pc, h) = pc[IDX_W+1:2] XOR zero-extend(h), using the low GHR_W bits of h.
  - When GHR_W = 0, idx = pc[IDX_W+1:2].
- Lookup (combinational):
  - pred_taken = pred_jump OR (pred_branch AND MSB of counter[idx(pred_pc, ghr)]).
  - pred_target = pred_pc + pred_imm, modulo 2^32.
  - pred_ghr = current ghr.
  - pred_taken is 0 unless pred_valid = 1.
- Speculative history:
  - Applies when rdy_in = 1, pred_valid = 1 and pred_branch = 1: ghr <= {ghr[GHR_W-2:0], pred_taken}.
  - JAL does not shift history.
  - When GHR_W = 1, ghr <= pred_taken.
- Resolve, applied on the edge when rdy_in = 1 and res_valid = 1:
  - The entry at idx(res_pc, res_ghr) saturates: +1 if res_taken, else -1.
  - Clamps at 0 and at 2^CNT_W - 1 with no wrap.
  - stat_branches increments.
- Mispredict (res_taken != res_pred_taken):
  - Next cycle: predict_fail = 1 for exactly one cycle.
  - fail_addr = res_taken ? res_target : res_pc + 4.
  - ghr <= {res_ghr[GHR_W-2:0], res_taken}.
  - stat_misses increments.
- Correct prediction: predict_fail = 0 next cycle, and ghr follows the speculative rule only.
- Simultaneous events in the same cycle:
  - Mispredict restore and lookup shift: restore wins, lookup shift discarded.
  - Lookup and update at the same index: lookup sees the pre-update value; the update lands at the edge.
- Statistics counters wrap modulo 2^STAT_W.
- rdy_in = 0:
  - No counter, ghr or stat update.
  - predict_fail and fail_addr hold their values.
  - A res_valid presented while rdy_in = 0 is ignored.
- Reset (rst_in = 0 at an edge, checked ahead of rdy_in):
  - All counters = 2^(CNT_W-1) - 1 (weakly not-taken).
  - ghr = 0; predict_fail = 0; fail_addr = 0; stats = 0.
  - Reset asserted mid-stream drops any pending predict_fail pulse.

Decomposition:
- Shared package (bp_pkg):
  - Default IDX_W / CNT_W / GHR_W.
  - Counter-init constant function.
  - Saturating-increment/decrement function.
  - Index hash function.
- One sub-module: bp_counter_table. Holds 2^IDX_W x CNT_W flops, one async read port and one sync write port, with the reset-init value as a parameter.
- The top level holds ghr, the fail pulse register and the statistics counters.

Test Plan:
- Reset then lookup: pred_branch = 1, pc = 0x100, imm = 0x20 -> pred_taken = 0, pred_target = 0x120, pred_ghr = 0.
- Training: resolve pc = 0x100, ghr = 0, taken = 1, pred = 0, twice (GHR_W = 0) -> predict_fail pulses each time with fail_addr = res_target = 0x120. Third lookup gives pred_taken = 1; stat_misses = 2.
- Saturation: five taken resolves at one index with CNT_W = 2 -> counter = 3. One not-taken resolve -> still predicts taken; a second not-taken resolve -> predicts not-taken.
- GHR recovery: three speculative taken lookups (ghr = 0b0111), then mispredict with res_ghr = 0b0001 and res_taken = 0 in the same cycle as a lookup -> ghr = 0b0010 next cycle.
- Not-taken miss: res_pc = 0x200, res_pred_taken = 1, res_taken = 0 -> fail_addr = 0x204, one-cycle pulse.
- rdy_in = 0 during res_valid -> no counter, stat or ghr change. Reset during a pulse cycle -> predict_fail = 0 next cycle.
